axi_fifo_pkt: RTL

Parametrised successor to the general AXI-stream FIFO: generic depth and width, carries tlast alongside data, and adds a packet mode plus almost-full/almost-empty flags and a packet counter. In packet mode a packet is presented downstream only once it is completely stored, with a forced-release escape for oversize packets. Sits between framers/deframers and DMA/radio paths wherever a full packet must be stored before it is forwarded.

---
 rtl/axi_fifo_pkg.sv | 31 +++
 rtl/axi_fifo_pkt_ram.sv | 47 ++++
 rtl/axi_fifo_pkt.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/axi_fifo_pkg.sv
// Shared helpers for the packet-aware AXI-stream FIFO: sizing function,
// default threshold values and the stored entry width.
package axi_fifo_pkg;

  localparam int DEF_SIZE         = 5;
  localparam int DEF_ALMOST_EMPTY = 2;
  localparam int AF_MARGIN        = 2;

  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Default almost-full point leaves AF_MARGIN free entries.
  function automatic int def_almost_full(input int size);
    return (1 << size) - AF_MARGIN;
  endfunction

  // Each entry stores tlast alongside tdata.
  function automatic int entry_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/axi_fifo_pkt_ram.sv
// Simple dual-port storage for the FIFO: one write port and one registered
// read port that doubles as the FIFO output register.
module axi_fifo_pkt_ram
  import axi_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_SIZE,
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register holds its value unless a new word is pulled.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_fifo_pkt.sv
// AXI-stream FIFO with tlast storage, optional store-and-forward packet mode
// with forced release for oversize packets, fill thresholds and packet count.
module axi_fifo_pkt
  import axi_fifo_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SIZE         = DEF_SIZE,
  parameter bit PKT_MODE     = 1'b0,
  parameter int ALMOST_FULL  = def_almost_full(SIZE),
  parameter int ALMOST_EMPTY = DEF_ALMOST_EMPTY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [15:0]      space,
  output logic [15:0]      occupied,
  output logic [15:0]      pkt_count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int          DEPTH   = 1 << SIZE;
  localparam int          PTR_W   = clog2(DEPTH);
  localparam int          ENTRY_W = entry_w(WIDTH);
  localparam logic [15:0] DEPTH_C = 16'(DEPTH);
  localparam logic [15:0] AF_C    = 16'(ALMOST_FULL);
  localparam logic [15:0] AE_C    = 16'(ALMOST_EMPTY);

  typedef struct packed {
    logic             tlast;
    logic [WIDTH-1:0] tdata;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]      occupied_q, occupied_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic             force_q, force_d;
  logic             o_valid_q, o_valid_d;
  logic             in_ready_q, in_ready_d;

  entry_t      wr_entry;
  entry_t      rd_entry;
  logic        wr_fire;
  logic        rd_fire;
  logic        full;
  logic        head_is_last;
  logic [15:0] ram_cnt;
  logic [15:0] ram_pkts;
  logic        gate;
  logic        load;

  // Handshake: a word moves on a clock edge only when valid and ready are both
  // high; valid never waits for ready, and i_tready is a registered "not full"
  // that ignores o_tready, so a full FIFO never writes through a read.
  assign i_tready = in_ready_q & ~clear;
  assign wr_fire  = i_tvalid & i_tready;
  assign rd_fire  = o_valid_q & o_tready & ~clear;
  assign full     = (occupied_q == DEPTH_C);
  assign wr_entry = {i_tlast, i_tdata};

  // The output register is the RAM read register, so words still in RAM are
  // occupied minus the one presented; likewise for complete packets.
  assign head_is_last = o_valid_q & rd_entry.tlast;
  assign ram_cnt      = occupied_q - 16'(o_valid_q);
  assign ram_pkts     = pkt_count_q - 16'(head_is_last);

  // A forced release stops once its tlast is presented, so the next
  // (possibly partial) packet is not pulled in behind it.
  assign gate = !PKT_MODE || (ram_pkts != '0) || (force_q && !head_is_last);
  assign load = ~clear & (ram_cnt != '0) & (~o_valid_q | o_tready) & gate;

  axi_fifo_pkt_ram #(
    .ADDR_W (PTR_W),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_en   (load),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_entry)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occupied_d  = occupied_q;
    pkt_count_d = pkt_count_q;
    force_d     = force_q;
    o_valid_d   = o_valid_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occupied_d  = '0;
      pkt_count_d = '0;
      force_d     = 1'b0;
      o_valid_d   = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (load) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      occupied_d  = occupied_q + 16'(wr_fire) - 16'(rd_fire);
      pkt_count_d = pkt_count_q + 16'(wr_fire & i_tlast)
                    - 16'(rd_fire & rd_entry.tlast);
      if (load) begin
        o_valid_d = 1'b1;
      end else if (rd_fire) begin
        o_valid_d = 1'b0;
      end
      // Full with no complete packet stored can only be an oversize packet.
      if (rd_fire && rd_entry.tlast) begin
        force_d = 1'b0;
      end else if (PKT_MODE && full && (pkt_count_q == '0)) begin
        force_d = 1'b1;
      end
    end
    in_ready_d = (occupied_d != DEPTH_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occupied_q  <= '0;
      pkt_count_q <= '0;
      force_q     <= 1'b0;
      o_valid_q   <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occupied_q  <= occupied_d;
      pkt_count_q <= pkt_count_d;
      force_q     <= force_d;
      o_valid_q   <= o_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign o_tdata      = rd_entry.tdata;
  assign o_tlast      = rd_entry.tlast;
  assign o_tvalid     = o_valid_q;
  assign occupied     = occupied_q;
  assign space        = DEPTH_C - occupied_q;
  assign pkt_count    = pkt_count_q;
  assign almost_full  = (occupied_q >= AF_C);
  assign almost_empty = (occupied_q <= AE_C);

endmodule
